// File: rtl/button_event_arbiter_pkg.sv
// Shared constants and types for the button event arbiter.
// Covers button indices, the repeat FSM state and the default button count.
package btn_evt_pkg;

    localparam int N_BTN_DEF = 5;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_e;

    // Index width that never collapses to zero for a single button.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event handshake between the arbiter (master) and the display/mode logic (slave).
interface button_event_arbiter_if
    import btn_evt_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    localparam int IW = idx_w(N_BTN);

    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_id;
    logic          evt_repeat;

    modport master (output evt_valid, evt_id, evt_repeat, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_repeat, output evt_ready);

endinterface

// File: rtl/button_event_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after the pointer wins.
// The pointer moves to one past the winner whenever adv is asserted.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!found && req[(int'(ptr_q) + off) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr_q) + off) % N);
                grant[(int'(ptr_q) + off) % N] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) ptr_d = (int'(idx) == N - 1) ? '0 : IW'(int'(idx) + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button levels -> one-shot press/auto-repeat events, one per handshake.
// Requests are latched as pending bits and drained round-robin into a single output stage.
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N_BTN        = N_BTN_DEF,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_BTN-1:0]      btn_in,
    input  logic                  en,
    button_event_arbiter_if.master evt,
    output logic [N_BTN-1:0]      pending,
    output logic                  overrun
);

    localparam int IW   = idx_w(N_BTN);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DLY_END  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_END = CW'(REPEAT_RATE - 1);

    logic [N_BTN-1:0] btn_q, btn_prev_q, btn_prev_d;
    logic             armed_q;
    logic [N_BTN-1:0] pend_q, pend_d, pend_rpt_q, pend_rpt_d;
    logic             evt_valid_q, evt_valid_d, evt_rpt_q, evt_rpt_d;
    logic [IW-1:0]    evt_id_q, evt_id_d;
    logic             overrun_q, overrun_d;

    rpt_state_e       state_q;
    logic [IW-1:0]    trk_q;
    logic [CW-1:0]    cnt_q;

    logic [N_BTN-1:0] rise, trk_mask, tick_v, set_v, clr_v, grant;
    logic [IW-1:0]    rise_idx, grant_idx;
    logic             pop1, hold_ok, tick, found, load;

    // The first cycle out of reset copies the live level into both stages,
    // so a button already held across reset never looks like a fresh rise.
    assign btn_prev_d = armed_q ? btn_q : btn_in;
    assign rise       = btn_q & ~btn_prev_q;
    assign pop1       = (btn_q != '0) && ((btn_q & (btn_q - N_BTN'(1))) == '0);

    always_comb begin
        rise_idx = '0;
        trk_mask = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (rise[i]) rise_idx = IW'(i);
            trk_mask[i] = (trk_q == IW'(i));
        end
    end

    assign hold_ok = (|(btn_q & trk_mask)) && pop1 && ((rise & ~trk_mask) == '0);
    assign tick    = hold_ok && (((state_q == DELAY)  && (cnt_q == DLY_END)) ||
                                 ((state_q == REPEAT) && (cnt_q == RATE_END)));
    assign tick_v  = tick ? trk_mask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            trk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((REPEAT_DELAY != 0) && (|rise) && pop1) begin
                        state_q <= DELAY;
                        trk_q   <= rise_idx;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (!hold_ok) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    rr_arbiter #(.N(N_BTN), .IW(IW)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (pend_q),
        .adv   (load),
        .grant (grant),
        .idx   (grant_idx),
        .found (found)
    );

    assign load  = en && found && (!evt_valid_q || evt.evt_ready);
    assign set_v = rise | tick_v;
    assign clr_v = load ? grant : '0;

    // A bit being handed out this cycle is free again, so a new request on it
    // is a fresh entry rather than an overrun.
    always_comb begin
        pend_d     = (pend_q & ~clr_v) | set_v;
        pend_rpt_d = pend_rpt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (set_v[i] && !(pend_q[i] && !clr_v[i])) pend_rpt_d[i] = !rise[i];
        end
        overrun_d = |(set_v & pend_q & ~clr_v);
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_rpt_d   = evt_rpt_q;
        if (load) begin
            evt_valid_d = 1'b1;
            evt_id_d    = grant_idx;
            evt_rpt_d   = |(grant & pend_rpt_q);
        end else if (evt_valid_q && evt.evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= '0;
            btn_prev_q  <= '0;
            armed_q     <= 1'b0;
            pend_q      <= '0;
            pend_rpt_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_rpt_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            btn_q       <= btn_in;
            btn_prev_q  <= btn_prev_d;
            armed_q     <= 1'b1;
            pend_q      <= pend_d;
            pend_rpt_q  <= pend_rpt_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_rpt_q   <= evt_rpt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign evt.evt_valid  = evt_valid_q;
    assign evt.evt_id     = evt_id_q;
    assign evt.evt_repeat = evt_rpt_q;
    assign pending        = pend_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench: a cycle table for press/arbitration order, then hand sequences
// for auto-repeat, back-pressure/overrun, enable gating and mid-operation reset.
module tb_button_event_arbiter;
    import btn_evt_pkg::*;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic         en = 1'b1;
    logic [N-1:0] pending;
    logic         overrun;

    button_event_arbiter_if #(.N_BTN(N)) bus ();

    button_event_arbiter #(.N_BTN(N), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_in),
        .en      (en),
        .evt     (bus),
        .pending (pending),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        bit rpt;
        int cyc;
    } ev_t;
    ev_t evq[$];
    ev_t ev_s;

    always @(negedge clk) begin
        if (rst_n && bus.evt_valid && bus.evt_ready) begin
            ev_s.id  = int'(bus.evt_id);
            ev_s.rpt = bus.evt_repeat;
            ev_s.cyc = cyc;
            evq.push_back(ev_s);
        end
    end

    typedef struct {
        logic [N-1:0] btn;
        logic         vld;
        int           id;
        logic [N-1:0] pend;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_in = '0;
        en = 1'b1;
        bus.evt_ready = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(3);
        evq.delete();
    endtask

    task automatic add(input logic [N-1:0] b, input logic v, input int id, input logic [N-1:0] p);
        vec_t t;
        t.btn = b; t.vld = v; t.id = id; t.pend = p;
        tbl.push_back(t);
    endtask

    initial begin
        int gap[4];
        bus.evt_ready = 1'b1;
        gap = '{20, 5, 5, 5};

        // Arbitration order 0,1,3 then 4,0; then a lone press of button 2.
        add(5'b01011, 0, 0, 5'b00000);
        add(5'b01011, 0, 0, 5'b01011);
        add(5'b01011, 1, 0, 5'b01010);
        add(5'b01011, 1, 1, 5'b01000);
        add(5'b00000, 1, 3, 5'b00000);
        add(5'b00000, 0, 0, 5'b00000);
        add(5'b10001, 0, 0, 5'b00000);
        add(5'b10001, 0, 0, 5'b10001);
        add(5'b10001, 1, 4, 5'b00001);
        add(5'b00000, 1, 0, 5'b00000);
        add(5'b00000, 0, 0, 5'b00000);
        add(5'b00100, 0, 0, 5'b00000);
        add(5'b00100, 0, 0, 5'b00100);
        add(5'b00100, 1, 2, 5'b00000);
        add(5'b00000, 0, 0, 5'b00000);
        add(5'b00000, 0, 0, 5'b00000);

        do_reset();
        chk("reset_valid", bus.evt_valid, 0);
        chk("reset_id", bus.evt_id, 0);
        chk("reset_repeat", bus.evt_repeat, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overrun", overrun, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            btn_in = tbl[i].btn;
            step(1);
            chk($sformatf("tbl%0d_valid", i), bus.evt_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_id", i), bus.evt_id, tbl[i].id);
                chk($sformatf("tbl%0d_repeat", i), bus.evt_repeat, 0);
            end
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_overrun", i), overrun, 0);
        end

        // Lone hold of button 1 for 40 cycles: press then repeats at 20,5,5,5.
        do_reset();
        btn_in = 5'(1 << BTN_U);
        step(40);
        btn_in = '0;
        step(10);
        chk("rpt_count", evq.size(), 5);
        for (int k = 0; k < evq.size() && k < 5; k++) begin
            chk($sformatf("rpt%0d_id", k), evq[k].id, 1);
            chk($sformatf("rpt%0d_flag", k), evq[k].rpt, (k > 0));
            if (k > 0) chk($sformatf("rpt%0d_gap", k), evq[k].cyc - evq[k-1].cyc, gap[k-1]);
        end

        // Second button joins after the first repeat: repeats stop.
        evq.delete();
        btn_in = 5'(1 << BTN_U);
        step(23);
        btn_in = 5'((1 << BTN_U) | (1 << BTN_D));
        step(20);
        btn_in = '0;
        step(10);
        chk("stop_count", evq.size(), 3);
        if (evq.size() == 3) begin
            chk("stop0_id", evq[0].id, 1);
            chk("stop0_rpt", evq[0].rpt, 0);
            chk("stop1_id", evq[1].id, 1);
            chk("stop1_rpt", evq[1].rpt, 1);
            chk("stop1_gap", evq[1].cyc - evq[0].cyc, 20);
            chk("stop2_id", evq[2].id, 2);
            chk("stop2_rpt", evq[2].rpt, 0);
        end

        // Back-pressure: event held, second press pends, third overruns.
        do_reset();
        bus.evt_ready = 1'b0;
        btn_in = 5'(1 << BTN_D);
        step(3);
        chk("bp_valid", bus.evt_valid, 1);
        chk("bp_id", bus.evt_id, 2);
        chk("bp_pend0", pending, 0);
        btn_in = '0;
        step(2);
        btn_in = 5'(1 << BTN_D);
        step(2);
        chk("bp_valid2", bus.evt_valid, 1);
        chk("bp_id2", bus.evt_id, 2);
        chk("bp_pend1", pending, 5'b00100);
        chk("bp_ovr0", overrun, 0);
        btn_in = '0;
        step(2);
        btn_in = 5'(1 << BTN_D);
        step(2);
        chk("bp_ovr1", overrun, 1);
        chk("bp_id3", bus.evt_id, 2);
        chk("bp_rpt3", bus.evt_repeat, 0);
        step(1);
        chk("bp_ovr_pulse", overrun, 0);
        btn_in = '0;
        step(1);
        bus.evt_ready = 1'b1;
        step(8);
        chk("bp_drain_count", evq.size(), 2);
        for (int k = 0; k < evq.size(); k++) chk($sformatf("bp_drain%0d_id", k), evq[k].id, 2);
        chk("bp_drain_valid", bus.evt_valid, 0);
        chk("bp_drain_pend", pending, 0);

        // Enable gating.
        do_reset();
        en = 1'b0;
        btn_in = 5'(1 << BTN_L);
        step(3);
        chk("en_valid0", bus.evt_valid, 0);
        chk("en_pend", pending, 5'b01000);
        step(1);
        chk("en_valid1", bus.evt_valid, 0);
        btn_in = '0;
        en = 1'b1;
        step(1);
        chk("en_valid2", bus.evt_valid, 1);
        chk("en_id", bus.evt_id, 3);
        chk("en_pend2", pending, 0);
        step(1);
        chk("en_valid3", bus.evt_valid, 0);
        chk("en_count", evq.size(), 1);

        // Reset while an event is presented and the FSM is repeating.
        do_reset();
        bus.evt_ready = 1'b0;
        btn_in = 5'(1 << BTN_C);
        step(25);
        chk("mr_valid", bus.evt_valid, 1);
        chk("mr_id", bus.evt_id, 0);
        chk("mr_pend_rpt", pending, 5'b00001);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_valid", bus.evt_valid, 0);
        chk("mr_rst_id", bus.evt_id, 0);
        chk("mr_rst_rpt", bus.evt_repeat, 0);
        chk("mr_rst_pend", pending, 0);
        chk("mr_rst_ovr", overrun, 0);
        step(2);
        rst_n = 1'b1;
        bus.evt_ready = 1'b1;
        step(30);
        chk("mr_held_events", evq.size(), 0);
        chk("mr_held_valid", bus.evt_valid, 0);
        chk("mr_held_pend", pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
